muldiv_sequencer: RTL and testbench

//  Iterative MULT/MULTU/DIV/DIVU engine and $hi/$lo write sequencer for the 5-stage pipeline.

---
 rtl/muldiv_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative MULT/MULTU/DIV/DIVU engine for the 5-stage pipeline. It accepts
// one operation from EX and works through it one bit per cycle. It then
// issues a single regfile write of the 64-bit {hi,lo} result under dest code
// HILO_DEST. While the engine is occupied, it stalls EX/ID whenever a new
// mul/div or an mfhi/mflo shows up.
//
// Parameters
//   XLEN       operand width; result width is 2*XLEN
//   HILO_DEST  regfile dest code that selects the {hi,lo} write
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   EX holds a mul/div op this cycle
//   op         in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val     in   operand A (multiplicand / dividend)
//   rt_val     in   operand B (multiplier / divisor)
//   flush      in   abort the in-flight op; no write is issued
//   hilo_use   in   ID holds mfhi/mflo
//   busy       out  engine occupied (any state but IDLE)
//   stall      out  busy & (start | hilo_use), combinational
//   hilo_we    out  one-cycle regfile write strobe
//   hilo_dest  out  HILO_DEST while hilo_we, else 0
//   prod       out  {hi,lo}, held from one completion to the next
//
// Configuration macro
//   MULDIV_EARLY_TERM_EN : a multiply leaves CALC as soon as the remaining
//                          multiplier bits are all zero (minimum 1 cycle).
//                          Divide timing is unaffected.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter int HILO_DEST = 34
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [XLEN-1:0]     rs_val,
    input  logic [XLEN-1:0]     rt_val,
    input  logic                flush,
    input  logic                hilo_use,
    output logic                busy,
    output logic                stall,
    output logic                hilo_we,
    output logic [5:0]          hilo_dest,
    output logic [2*XLEN-1:0]   prod
);

    localparam int               CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [XLEN-1:0]     rs_raw_q, rs_raw_d;
    logic [XLEN-1:0]     rt_raw_q, rt_raw_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplier_q, mplier_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   res_q, res_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;

    logic                is_mul;
    logic                is_signed;
    logic                calc_last;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN:0]       cand;
    logic [XLEN-1:0]     rem_sub;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;

    assign is_mul    = ~op_q[1];
    assign is_signed = ~op_q[0];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A flush in any busy state, DONE included, returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !flush) state_d = PREP;
            PREP:    state_d = CALC;
            CALC:    if (calc_last) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Output logic. During DONE, prod already shows the new result so that it
    // travels with the write strobe. A flush in DONE suppresses both.
    always_comb begin
        busy      = (state_q != IDLE);
        stall     = busy & (start | hilo_use);
        hilo_we   = (state_q == DONE) && !flush;
        hilo_dest = hilo_we ? 6'(HILO_DEST) : 6'd0;
        prod      = hilo_we ? res_q : prod_q;
    end

    // Datapath.
    // Magnitudes are formed by an XLEN-bit two's-complement negation read as
    // unsigned. For -2^(XLEN-1) this yields 2^(XLEN-1), so the most negative
    // operand needs no special case.
    // Multiply: left-shifting multiplicand, right-shifting multiplier.
    // The multiplier register reaches zero exactly when no partial products
    // remain, and early termination relies on that.
    // Divide: restoring, with {remainder, dividend/quotient} held in acc.
    always_comb begin
        op_d      = op_q;
        rs_raw_d  = rs_raw_q;
        rt_raw_d  = rt_raw_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        prod_d    = prod_q;
        a_mag     = '0;
        b_mag     = '0;
        cand      = '0;
        rem_sub   = '0;
        quo_fix   = '0;
        rem_fix   = '0;
        calc_last = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d     = op;
                    rs_raw_d = rs_val;
                    rt_raw_d = rt_val;
                    cnt_d    = '0;
                end
            end

            PREP: begin
                sa_d     = is_signed & rs_raw_q[XLEN-1];
                sb_d     = is_signed & rt_raw_q[XLEN-1];
                a_mag    = sa_d ? -rs_raw_q : rs_raw_q;
                b_mag    = sb_d ? -rt_raw_q : rt_raw_q;
                mcand_d  = {{XLEN{1'b0}}, a_mag};
                mplier_d = b_mag;
                acc_d    = is_mul ? '0 : {{XLEN{1'b0}}, a_mag};
                cnt_d    = '0;
            end

            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_mul) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    // Shift the next dividend bit into the partial remainder.
                    // If the trial fits, the subtraction cannot overflow XLEN bits.
                    cand    = acc_q[2*XLEN-1:XLEN-1];
                    rem_sub = cand[XLEN-1:0] - mplier_q;
                    if (cand >= {1'b0, mplier_q}) begin
                        acc_d = {rem_sub, acc_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                    end
                end
`ifdef MULDIV_EARLY_TERM_EN
                calc_last = is_mul ? (mplier_d == '0) : (cnt_q == CNT_LAST);
`else
                calc_last = (cnt_q == CNT_LAST);
`endif
            end

            FIX: begin
                if (is_mul) begin
                    res_d = (sa_q ^ sb_q) ? -acc_q : acc_q;
                end else if (mplier_q == '0) begin
                    // Divide by zero: raw dividend in hi, all ones in lo.
                    res_d = {rs_raw_q, {XLEN{1'b1}}};
                end else begin
                    quo_fix = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                    rem_fix = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                    res_d   = {rem_fix, quo_fix};
                end
            end

            DONE: begin
                if (!flush) begin
                    prod_d = res_q;
                end
            end

            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            rs_raw_q <= '0;
            rt_raw_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            prod_q   <= '0;
        end else begin
            op_q     <= op_d;
            rs_raw_q <= rs_raw_d;
            rt_raw_q <= rt_raw_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer. Results come from a plain-arithmetic
// reference (64-bit products, C-style truncating divide). Latencies come from
// the documented cycle counts. Directed cases cover the edge operands, stall,
// flush and async reset. A randomized loop covers everything else.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        hilo_use;
    logic        busy;
    logic        stall;
    logic        hilo_we;
    logic [5:0]  hilo_dest;
    logic [63:0] prod;

    int          vectors;
    int          miscompares;
    logic [63:0] lastProd;

    muldiv_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .flush     (flush),
        .hilo_use  (hilo_use),
        .busy      (busy),
        .stall     (stall),
        .hilo_we   (hilo_we),
        .hilo_dest (hilo_dest),
        .prod      (prod)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result built from ordinary integer arithmetic.
    function automatic logic [63:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    qv = 64'(q);
                    rv = 64'(r);
                end else begin
                    qv = ua / ub;
                    rv = ua % ub;
                end
                return {rv[31:0], qv[31:0]};
            end
        endcase
    endfunction

    // Expected cycle index of hilo_we, counting the cycle after acceptance as 1.
    function automatic int refLatency(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] mag;
        int          msb;
        mag = (o == 2'b00 && b[31]) ? -b : b;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) msb = i;
        end
`ifdef MULDIV_EARLY_TERM_EN
        if (o[1] == 1'b0) return (msb < 0) ? 4 : 4 + msb;
`endif
        return 35;
    endfunction

    // Launch one operation and check latency, strobe, dest and result.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          expLat;
        int          cyc;
        exp    = refResult(o, a, b);
        expLat = refLatency(o, b);
        @(negedge clock);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clock); #1;
        start = 1'b0;
        cyc   = 1;
        checkOutput({tag, "_busy"}, busy, 1);
        while (!hilo_we && cyc < 60) begin
            checkOutput({tag, "_prodhold"}, prod, lastProd);
            @(posedge clock); #1;
            cyc++;
        end
        checkOutput({tag, "_lat"}, cyc, expLat);
        checkOutput({tag, "_we"}, hilo_we, 1);
        checkOutput({tag, "_dest"}, hilo_dest, 34);
        checkOutput({tag, "_prod"}, prod, exp);
        @(posedge clock); #1;
        checkOutput({tag, "_idle"}, busy, 0);
        checkOutput({tag, "_weoff"}, hilo_we, 0);
        checkOutput({tag, "_held"}, prod, exp);
        lastProd = exp;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] prod1;
        logic [63:0] prod2;
        int          lat1;
        int          lat2;
        int          c;
        logic        sawWe;

        vectors     = 0;
        miscompares = 0;
        lastProd    = 64'd0;
        reset       = 1'b1;
        start       = 1'b0;
        op          = 2'b00;
        rs_val      = 32'd0;
        rt_val      = 32'd0;
        flush       = 1'b0;
        hilo_use    = 1'b1;
        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_we", hilo_we, 0);
        checkOutput("rst_dest", hilo_dest, 0);
        checkOutput("rst_prod", prod, 0);
        @(negedge clock);
        reset    = 1'b0;
        hilo_use = 1'b0;

        // Directed edge operands.
        applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu_max_const", lastProd, 64'hFFFF_FFFE_0000_0001);
        applyStimulus("mult_neg", 2'b00, -32'd3, 32'd7);
        checkOutput("mult_neg_const", prod, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus("div_neg", 2'b10, -32'd7, 32'd2);
        checkOutput("div_neg_const", prod, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        applyStimulus("divu_zero", 2'b11, 32'd100, 32'd0);
        checkOutput("divu_zero_const", prod, {32'd100, 32'hFFFF_FFFF});
        applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf_const", prod, {32'd0, 32'h8000_0000});
        applyStimulus("div_zero_neg", 2'b10, -32'd9, 32'd0);
        applyStimulus("multu_5x3", 2'b01, 32'd5, 32'd3);
        applyStimulus("mult_bzero", 2'b00, 32'd77, 32'd0);

        // Stall: hilo_use from cycle 5, second start from cycle 10, held until taken.
        prod1 = refResult(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        lat1  = refLatency(2'b01, 32'h9ABC_DEF0);
        prod2 = refResult(2'b11, 32'd1000, 32'd7);
        lat2  = refLatency(2'b11, 32'd7);
        @(negedge clock);
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'h1234_5678;
        rt_val = 32'h9ABC_DEF0;
        @(posedge clock); #1;
        start = 1'b0;
        c     = 1;
        while (c <= lat1) begin
            @(posedge clock); #1;
            c++;
            hilo_use = (c >= 5);
            if (c >= 10) begin
                start  = 1'b1;
                op     = 2'b11;
                rs_val = 32'd1000;
                rt_val = 32'd7;
            end
            #1;
            if (c == 5 || c == 10 || c == lat1) checkOutput("stall_busy", stall, 1);
            if (c == lat1) begin
                checkOutput("stall_first_we", hilo_we, 1);
                checkOutput("stall_first_prod", prod, prod1);
            end
            if (c == lat1 + 1) begin
                checkOutput("stall_idle_busy", busy, 0);
                checkOutput("stall_idle_stall", stall, 0);
                checkOutput("stall_idle_prod", prod, prod1);
            end
        end
        @(posedge clock); #1;
        start    = 1'b0;
        hilo_use = 1'b0;
        checkOutput("second_accept", busy, 1);
        c = 1;
        while (!hilo_we && c < 60) begin
            @(posedge clock); #1;
            c++;
        end
        checkOutput("second_lat", c, lat2);
        checkOutput("second_prod", prod, prod2);
        lastProd = prod2;
        @(posedge clock); #1;

        // Flush in mid-computation: no write, prod keeps its old value.
        @(negedge clock);
        start  = 1'b1;
        op     = 2'b10;
        rs_val = 32'd12345;
        rt_val = 32'd17;
        @(posedge clock); #1;
        start = 1'b0;
        c     = 1;
        sawWe = 1'b0;
        while (c < 20) begin
            @(posedge clock); #1;
            c++;
            if (hilo_we) sawWe = 1'b1;
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_prod", prod, lastProd);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (hilo_we) sawWe = 1'b1;
        end
        checkOutput("flush_nowe", sawWe, 0);
        checkOutput("flush_prod_later", prod, lastProd);

        // Flush during the DONE cycle cancels the write.
        @(negedge clock);
        start  = 1'b1;
        op     = 2'b00;
        rs_val = 32'd1111;
        rt_val = -32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        c     = 1;
        while (!hilo_we && c < 60) begin
            @(posedge clock); #1;
            c++;
        end
        checkOutput("fdone_reach", hilo_we, 1);
        flush = 1'b1;
        #1;
        checkOutput("fdone_we", hilo_we, 0);
        checkOutput("fdone_dest", hilo_dest, 0);
        checkOutput("fdone_prod", prod, lastProd);
        @(posedge clock); #1;
        flush = 1'b0;
        checkOutput("fdone_busy", busy, 0);
        checkOutput("fdone_prod_after", prod, lastProd);

        // Flush while idle blocks acceptance.
        @(negedge clock);
        start  = 1'b1;
        flush  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd2;
        rt_val = 32'd2;
        @(posedge clock); #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("idle_flush_block", busy, 0);

        // Async reset mid-operation clears everything at once.
        @(negedge clock);
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd999;
        rt_val = 32'd4;
        @(posedge clock); #1;
        start    = 1'b0;
        hilo_use = 1'b1;
        for (int i = 1; i < 15; i++) begin
            @(posedge clock); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_busy", busy, 0);
        checkOutput("areset_stall", stall, 0);
        checkOutput("areset_we", hilo_we, 0);
        checkOutput("areset_dest", hilo_dest, 0);
        checkOutput("areset_prod", prod, 0);
        @(negedge clock);
        reset    = 1'b0;
        hilo_use = 1'b0;
        lastProd = 64'd0;

        // Randomized operations against the reference.
        for (int n = 0; n < 40; n++) begin
            applyStimulus("rand", 2'($urandom_range(0, 3)), pickOperand(), pickOperand());
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
